trace_capture_fifo: RTL and testbench

TRACE_CAPTURE_FIFO -- requirements
Module: trace_capture_fifo

---
 rtl/trace_capture_fifo.sv | 174 +++++++++++++++++
 tb/tb_trace_capture_fifo.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// trace_capture_fifo
//
// Captures retired-instruction trace from a two-lane core trace port into a
// small FIFO for later read-out by a consumer. Each valid lane becomes one
// entry. Lane 0 is pushed before lane 1. When space runs out, entries are
// dropped and the drops are accounted for. A three-state capture FSM
// (OFF / RUN / STOPPED) gates sampling. STOPPED lets a capture freeze on its
// first drop, so the earliest history is preserved.
//
// Optional feature (compile-time macro TRACE_FIFO_TVAL_EN):
//   defined   : EW = 103, trace_rv_i_tval_ip is stored in bits [102:71]
//   undefined : EW = 71,  trace_rv_i_tval_ip is ignored (port still present)
//
// Entry layout, LSB first: insn[31:0], addr[63:32], exc[64], intr[65],
// ecause[70:66], tval[102:71] (only when compiled in).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   trace_rv_i_*_ip           core trace port. Lane 0 is in the low 32 bits
//                             or bit 0, lane 1 is in the next 32 bits or
//                             bit 1. Bit 2 of the 3-bit fields is ignored.
//                             ecause and tval are shared by both lanes.
//   cap_en                    capture enable
//   stop_on_full              move to STOPPED on the first drop
//   clear                     flush FIFO and status. Same-cycle push and
//                             pop are suppressed.
//   out_valid/out_ready       head-of-FIFO handshake, out_data = oldest entry
//   fill_level                occupied entries (0..DEPTH)
//   overflow                  sticky flag, set on any drop
//   drop_cnt                  saturating count of dropped entries
//   cap_state                 0 OFF, 1 RUN, 2 STOPPED
// -----------------------------------------------------------------------------
module trace_capture_fifo #(
    parameter int DEPTH      = 16,
    parameter int DROP_CNT_W = 16,
`ifdef TRACE_FIFO_TVAL_EN
    localparam int EW        = 103,
`else
    localparam int EW        = 71,
`endif
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           trace_rv_i_insn_ip,
    input  logic [63:0]           trace_rv_i_address_ip,
    input  logic [2:0]            trace_rv_i_valid_ip,
    input  logic [2:0]            trace_rv_i_exception_ip,
    input  logic [2:0]            trace_rv_i_interrupt_ip,
    input  logic [4:0]            trace_rv_i_ecause_ip,
    input  logic [31:0]           trace_rv_i_tval_ip,
    input  logic                  cap_en,
    input  logic                  stop_on_full,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EW-1:0]         out_data,
    output logic [CW-1:0]         fill_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [1:0]            cap_state
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t                r_state;
    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic [EW-1:0]         w_entry [2];
    logic                  w_run;
    logic [CW-1:0]         w_free;
    logic                  w_push0;
    logic                  w_push1;
    logic                  w_drop0;
    logic                  w_drop1;
    logic                  w_drop;
    logic                  w_pop;
    logic [AW-1:0]         w_wr1_ptr;
    logic [DROP_CNT_W:0]   w_drop_sum;

    // Per-lane entry assembly.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef TRACE_FIFO_TVAL_EN
        assign w_entry[gi] = {trace_rv_i_tval_ip, trace_rv_i_ecause_ip,
                              trace_rv_i_interrupt_ip[gi], trace_rv_i_exception_ip[gi],
                              trace_rv_i_address_ip[32*gi +: 32], trace_rv_i_insn_ip[32*gi +: 32]};
`else
        assign w_entry[gi] = {trace_rv_i_ecause_ip,
                              trace_rv_i_interrupt_ip[gi], trace_rv_i_exception_ip[gi],
                              trace_rv_i_address_ip[32*gi +: 32], trace_rv_i_insn_ip[32*gi +: 32]};
`endif
    end

    // Inputs that are intentionally not consumed in every build.
    logic w_unused;
    assign w_unused = ^{trace_rv_i_tval_ip, trace_rv_i_valid_ip[2],
                        trace_rv_i_exception_ip[2], trace_rv_i_interrupt_ip[2]};

    // Space is taken from the pre-pop count, so a pop in the same cycle never
    // makes room for a push. Lane 1 only gets a slot left over after lane 0.
    assign w_run     = (r_state == ST_RUN) && !clear;
    assign w_free    = CW'(DEPTH) - r_count;
    assign w_push0   = w_run && trace_rv_i_valid_ip[0] && (w_free != '0);
    assign w_push1   = w_run && trace_rv_i_valid_ip[1] && (w_free > CW'(w_push0));
    assign w_drop0   = w_run && trace_rv_i_valid_ip[0] && !w_push0;
    assign w_drop1   = w_run && trace_rv_i_valid_ip[1] && !w_push1;
    assign w_drop    = w_drop0 || w_drop1;
    assign w_pop     = (r_count != '0) && out_ready && !clear;
    assign w_wr1_ptr = r_wr_ptr + AW'(w_push0);

    // One extra bit catches the carry, which is used to saturate the count.
    assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drop0) + (DROP_CNT_W+1)'(w_drop1);

    // Storage is not reset. Only the pointers and the count define content.
    always_ff @(posedge clk) begin
        if (w_push0) r_mem[r_wr_ptr]  <= w_entry[0];
        if (w_push1) r_mem[w_wr1_ptr] <= w_entry[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_state    <= ST_OFF;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            end
            case (r_state)
                ST_OFF:     if (cap_en) r_state <= ST_RUN;
                ST_RUN: begin
                    if (!cap_en)                    r_state <= ST_OFF;
                    else if (stop_on_full && w_drop) r_state <= ST_STOPPED;
                end
                ST_STOPPED: if (!cap_en) r_state <= ST_OFF;
                default:    r_state <= ST_OFF;
            endcase
        end
    end

    assign out_valid  = (r_count != '0);
    // Masked so that an empty FIFO presents zero rather than stale storage.
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fill_level = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;
    assign cap_state  = r_state;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// tb_trace_capture_fifo
//
// Directed, self-checking bench for trace_capture_fifo (DEPTH = 16).
// Expected entries are pushed to a scoreboard queue when stimulus is driven.
// They are popped and compared when the DUT presents them on out_data.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_trace_capture_fifo;

`ifdef TRACE_FIFO_TVAL_EN
    localparam int EW = 103;
`else
    localparam int EW = 71;
`endif
    localparam int DEPTH = 16;

    typedef logic [EW-1:0] entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   insn = '0;
    logic [63:0]   addr = '0;
    logic [2:0]    valid = '0;
    logic [2:0]    exc = '0;
    logic [2:0]    intr = '0;
    logic [4:0]    ecause = '0;
    logic [31:0]   tval = '0;
    logic          cap_en = 1'b0;
    logic          stop_on_full = 1'b0;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] out_data;
    logic [4:0]    fill_level;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [1:0]    cap_state;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    trace_capture_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .trace_rv_i_insn_ip      (insn),
        .trace_rv_i_address_ip   (addr),
        .trace_rv_i_valid_ip     (valid),
        .trace_rv_i_exception_ip (exc),
        .trace_rv_i_interrupt_ip (intr),
        .trace_rv_i_ecause_ip    (ecause),
        .trace_rv_i_tval_ip      (tval),
        .cap_en                  (cap_en),
        .stop_on_full            (stop_on_full),
        .clear                   (clear),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .fill_level              (fill_level),
        .overflow                (overflow),
        .drop_cnt                (drop_cnt),
        .cap_state               (cap_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference entry built from the field layout. Bits above EW are truncated.
    function automatic entry_t exp_lane(input int l);
        logic [102:0] full;
        full = {tval, ecause, intr[l], exc[l], addr[32*l +: 32], insn[32*l +: 32]};
        return full[EW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [2:0] v, input logic [31:0] i0, input logic [31:0] a0,
                             input logic [31:0] i1, input logic [31:0] a1);
        valid = v;
        insn  = {i1, i0};
        addr  = {a1, a0};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_checks++; if (cap_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d required=0", cap_state); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill got=%0d required=0", fill_level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b required=0", out_valid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b required=0", overflow); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got=%0d required=0", drop_cnt); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h required=0", out_data); end
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_single;
        entry_t e;
        // Trace present in the cycle cap_en rises must not be captured.
        cap_en = 1'b1;
        set_lanes(3'b001, 32'hBADBAD00, 32'h0000DEAD, 32'h0, 32'h0);
        tick;
        n_checks++; if (cap_state !== 2'd1) begin n_fail++; $display("FAIL single_run got=%0d required=1", cap_state); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL single_rise_nocap got=%0d required=0", fill_level); end
        set_lanes(3'b001, 32'h00000013, 32'h80000000, 32'h0, 32'h0);
        sb.push_back(exp_lane(0));
        tick;
        valid = 3'b000;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b required=1", out_valid); end
        n_checks++; if (out_data[63:0] !== 64'h80000000_00000013) begin n_fail++; $display("FAIL single_data got=%h required=8000000000000013", out_data[63:0]); end
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL single_fill got=%0d required=1", fill_level); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL single_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL single_pop got=%h required=%h", out_data, e); end
                else $display("single pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
    endtask

    task automatic test_dual;
        entry_t e;
        exc = 3'b110; intr = 3'b101; ecause = 5'h1A; tval = 32'hCAFEF00D;
        set_lanes(3'b111, 32'h000000A0, 32'h00000100, 32'h000000A1, 32'h00000104);
        sb.push_back(exp_lane(0));
        sb.push_back(exp_lane(1));
        tick;
        valid = 3'b000;
        n_checks++; if (fill_level !== 5'd2) begin n_fail++; $display("FAIL dual_fill got=%0d required=2", fill_level); end
        n_checks++; if (out_data[63:32] !== 32'h100) begin n_fail++; $display("FAIL dual_first_addr got=%h required=100", out_data[63:32]); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL dual_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL dual_pop got=%h required=%h", out_data, e); end
                else $display("dual pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL dual_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
        exc = '0; intr = '0; ecause = '0; tval = '0;
    endtask

    task automatic test_fill_overflow;
        entry_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_lanes(3'b011, 32'h1000 + 2*c, 32'h2000 + 8*c, 32'h1001 + 2*c, 32'h2004 + 8*c);
            sb.push_back(exp_lane(0));
            sb.push_back(exp_lane(1));
            tick;
        end
        set_lanes(3'b011, 32'hBAD0, 32'hBAD0, 32'hBAD1, 32'hBAD4);
        tick;
        valid = 3'b000;
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL ovf_fill got=%0d required=16", fill_level); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got=%0d required=2", drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b required=1", overflow); end
        n_checks++; if (cap_state !== 2'd1) begin n_fail++; $display("FAIL ovf_state got=%0d required=1", cap_state); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL ovf_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL ovf_pop got=%h required=%h", out_data, e); end
                else $display("ovf pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
        n_checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_sticky got=%b/%0d required=1/2", overflow, drop_cnt); end
    endtask

    task automatic test_clear;
        entry_t e;
        set_lanes(3'b011, 32'h11, 32'h400, 32'h12, 32'h404);
        tick;
        // Clear with lanes valid and out_ready high: push and pop are both suppressed.
        clear = 1'b1; cap_en = 1'b1; out_ready = 1'b1;
        tick;
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL clear_fill got=%0d required=0", fill_level); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_drop got=%0d required=0", drop_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow got=%b required=0", overflow); end
        n_checks++; if (cap_state !== 2'd0) begin n_fail++; $display("FAIL clear_state_off got=%0d required=0", cap_state); end
        clear = 1'b0; out_ready = 1'b0;
        tick;
        n_checks++; if (cap_state !== 2'd1) begin n_fail++; $display("FAIL clear_state_run got=%0d required=1", cap_state); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL clear_off_nocap got=%0d required=0", fill_level); end
        tval = 32'hDEADBEEF;
        set_lanes(3'b001, 32'h77, 32'h300, 32'h0, 32'h0);
        sb.push_back(exp_lane(0));
        tick;
        valid = 3'b000;
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL clear_refill got=%0d required=1", fill_level); end
`ifdef TRACE_FIFO_TVAL_EN
        n_checks++; if (out_data[102:71] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clear_tval got=%h required=deadbeef", out_data[102:71]); end
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL clear_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL clear_pop got=%h required=%h", out_data, e); end
                else $display("clear pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        tval = '0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
    endtask

    task automatic test_stop_on_full;
        entry_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            set_lanes(3'b011, 32'h3000 + 2*c, 32'h4000 + 8*c, 32'h3001 + 2*c, 32'h4004 + 8*c);
            sb.push_back(exp_lane(0));
            sb.push_back(exp_lane(1));
            tick;
        end
        set_lanes(3'b001, 32'h30FF, 32'h40FC, 32'h0, 32'h0);
        sb.push_back(exp_lane(0));
        tick;
        n_checks++; if (fill_level !== 5'd15) begin n_fail++; $display("FAIL stop_fill15 got=%0d required=15", fill_level); end
        stop_on_full = 1'b1;
        set_lanes(3'b011, 32'h3100, 32'h4100, 32'h3101, 32'h4104);
        sb.push_back(exp_lane(0));
        tick;
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL stop_fill16 got=%0d required=16", fill_level); end
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL stop_drop got=%0d required=1", drop_cnt); end
        n_checks++; if (cap_state !== 2'd2) begin n_fail++; $display("FAIL stop_state got=%0d required=2", cap_state); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL stop_overflow got=%b required=1", overflow); end
        set_lanes(3'b011, 32'h3200, 32'h4200, 32'h3201, 32'h4204);
        tick; tick; tick;
        n_checks++; if (fill_level !== 5'd16 || drop_cnt !== 16'd1) begin n_fail++; $display("FAIL stop_ignored got=%0d/%0d required=16/1", fill_level, drop_cnt); end
        valid = 3'b000;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL stop_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL stop_pop got=%h required=%h", out_data, e); end
                else $display("stop pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stop_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
        n_checks++; if (cap_state !== 2'd2) begin n_fail++; $display("FAIL stop_hold got=%0d required=2", cap_state); end
        cap_en = 1'b0; stop_on_full = 1'b0;
        tick;
        n_checks++; if (cap_state !== 2'd0) begin n_fail++; $display("FAIL stop_to_off got=%0d required=0", cap_state); end
    endtask

    task automatic test_full_pushpop;
        entry_t e;
        cap_en = 1'b1;
        tick;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_lanes(3'b011, 32'h7000 + 2*c, 32'h8000 + 8*c, 32'h7001 + 2*c, 32'h8004 + 8*c);
            sb.push_back(exp_lane(0));
            sb.push_back(exp_lane(1));
            tick;
        end
        n_checks++; if (fill_level !== 5'd16) begin n_fail++; $display("FAIL fpp_fill16 got=%0d required=16", fill_level); end
        // Head is popped this cycle, but the push still sees a full FIFO.
        e = sb.pop_front();
        n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL fpp_head got=%h required=%h", out_data, e); end
        set_lanes(3'b001, 32'hF00, 32'hF00, 32'h0, 32'h0);
        out_ready = 1'b1;
        tick;
        valid = 3'b000; out_ready = 1'b0;
        n_checks++; if (fill_level !== 5'd15) begin n_fail++; $display("FAIL fpp_fill15 got=%0d required=15", fill_level); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL fpp_drop got=%0d required=2", drop_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL fpp_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL fpp_pop got=%h required=%h", out_data, e); end
                else $display("fpp pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
    endtask

    task automatic test_back_to_back;
        entry_t e;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL b2b_valid got=%b required=1", out_valid); end
                else begin
                    e = sb.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL b2b_pop got=%h required=%h", out_data, e); end
                    else $display("b2b pop %h", out_data);
                end
            end
            set_lanes(3'b001, 32'h5000 + c, 32'h6000 + 4*c, 32'h0, 32'h0);
            sb.push_back(exp_lane(0));
            tick;
        end
        valid = 3'b000;
        n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL b2b_fill got=%0d required=1", fill_level); end
        for (int k = 0; k < 40 && out_valid; k++) begin
            n_checks++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_pop got=%h required=no entry", out_data); end
            else begin
                e = sb.pop_front();
                if (out_data !== e) begin n_fail++; $display("FAIL b2b_pop got=%h required=%h", out_data, e); end
                else $display("b2b pop %h", out_data);
            end
            tick;
        end
        out_ready = 1'b0;
        n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got left=%0d valid=%b required 0/0", sb.size(), out_valid); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_dual;
        test_fill_overflow;
        test_clear;
        test_stop_on_full;
        test_full_pushpop;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
